// File: rtl/alu32_vector_checker.sv
// rtl/alu32_vector_checker.sv - self-test sequencer driving an 8-op ALU and scoring each vector
module alu32_vector_checker #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [WIDTH-1:0]     vec_in1,
    input  logic [WIDTH-1:0]     vec_in2,
    input  logic                 vec_ci,
    input  logic [8*WIDTH-1:0]   vec_exp,
    input  logic                 vec_exp_co,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    output logic                 alu_ci,
    output logic [2:0]           alu_a,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_co,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_pass,
    output logic [7:0]           res_fail_mask,
    input  logic                 clear,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_REPORT
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SW-1:0]         r_settle;
    logic [8*WIDTH-1:0]    r_exp;
    logic                  r_exp_co;

    logic                  w_accept;
    logic                  w_sample;
    logic                  w_last;
    logic                  w_release;
    logic                  w_miss;
    logic [7:0]            w_mask_next;
    logic [WIDTH-1:0]      w_exp_arr [8];

    // Unpack the latched expected results so the current opcode selects its slice directly.
    for (genvar k = 0; k < 8; k++) begin : g_exp
        assign w_exp_arr[k] = r_exp[k*WIDTH +: WIDTH];
    end

    assign vec_ready   = (r_state == S_IDLE) && !res_valid;
    assign w_accept    = vec_valid && vec_ready;
    assign w_sample    = (r_state == S_RUN) && (r_settle == SETTLE_LAST);
    assign w_last      = w_sample && (alu_a == 3'd7);
    assign w_release   = (r_state == S_REPORT) && res_valid && res_ready;
    // Carry-out only matters for the Add opcode; every other opcode compares the result bus alone.
    assign w_miss      = (alu_out != w_exp_arr[alu_a]) ||
                         ((alu_a == 3'd4) && (alu_co != r_exp_co));
    assign w_mask_next = res_fail_mask | ({7'b0, w_miss} << alu_a);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: accept a vector, walk all eight opcodes, then hold the report for the consumer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)  w_state_next = S_RUN;
            S_RUN:    if (w_last)    w_state_next = S_REPORT;
            S_REPORT: if (w_release) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Operand/opcode drive, settle timing and per-opcode result scoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_ci        <= 1'b0;
            alu_a         <= 3'd0;
            r_exp         <= '0;
            r_exp_co      <= 1'b0;
            r_settle      <= '0;
            res_valid     <= 1'b0;
            res_pass      <= 1'b0;
            res_fail_mask <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_in1       <= vec_in1;
                        alu_in2       <= vec_in2;
                        alu_ci        <= vec_ci;
                        alu_a         <= 3'd0;
                        r_exp         <= vec_exp;
                        r_exp_co      <= vec_exp_co;
                        r_settle      <= '0;
                        res_pass      <= 1'b0;
                        res_fail_mask <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (w_sample) begin
                        r_settle      <= '0;
                        res_fail_mask <= w_mask_next;
                        if (alu_a == 3'd7) begin
                            res_valid <= 1'b1;
                            res_pass  <= (w_mask_next == 8'd0);
                        end else begin
                            alu_a <= alu_a + 3'd1;
                        end
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_REPORT: begin
                    if (w_release) begin
                        res_valid <= 1'b0;
                        alu_a     <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating pass/fail tallies, bumped once per vector on its final sample; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clear) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (w_last) begin
            if (w_mask_next == 8'd0) begin
                if (!(&pass_cnt)) pass_cnt <= pass_cnt + CNT_ONE;
            end else begin
                if (!(&fail_cnt)) fail_cnt <= fail_cnt + CNT_ONE;
            end
        end
    end

endmodule
